// File: rtl/program_loader.sv
// program_loader: operator-driven writer for the instruction memory.
// Each 32-bit program word is entered as two 16-bit halves from the board
// switches (low half first), each confirmed by a debounced key press. While
// loading, the processor is held so the PC and register file stay frozen.
//
// Write-port handshake: Mem_Write is a one-cycle strobe with no back-pressure.
// Mem_Address and Mem_Write_Data are meaningful only in the cycle Mem_Write=1
// and hold their last values otherwise. The memory must accept the write in
// that cycle.
module program_loader #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [17:0]           Switches,
  input  logic                  Load_Key,
  input  logic                  Load_Enable,
  output logic [ADDR_WIDTH-1:0] Mem_Address,
  output logic [31:0]           Mem_Write_Data,
  output logic                  Mem_Write,
  output logic                  Processor_Hold,
  output logic [ADDR_WIDTH:0]   Word_Count,
  output logic                  Load_Done,
  output logic [2:0]            state_dbg
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]         DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOW   = 3'd1,
    HIGH  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                state;
  logic                  key_s1;
  logic                  key_s2;
  logic                  deb_level;
  logic [CW-1:0]         deb_cnt;
  logic                  press;
  logic [ADDR_WIDTH-1:0] addr;
  logic [15:0]           low_half;

  // Switch bit 17 has no function on this board.
  logic unused_sw17;
  assign unused_sw17 = Switches[17];

  assign state_dbg = state;

  // Key path: two-flop synchronizer, then a counter that only accepts a new
  // level after DEBOUNCE_CYCLES consecutive cycles of it. A 0->1 acceptance
  // produces a one-cycle press pulse; releases produce nothing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_s1    <= 1'b0;
      key_s2    <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
      press     <= 1'b0;
    end else begin
      key_s1 <= Load_Key;
      key_s2 <= key_s1;
      press  <= 1'b0;
      if (key_s2 == deb_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_level <= key_s2;
        deb_cnt   <= '0;
        press     <= key_s2;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Loader FSM with registered outputs; the write strobe is raised on entry
  // to WRITE so it lines up with that single-cycle state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      addr           <= '0;
      low_half       <= '0;
      Mem_Address    <= '0;
      Mem_Write_Data <= '0;
      Mem_Write      <= 1'b0;
      Processor_Hold <= 1'b0;
      Word_Count     <= '0;
      Load_Done      <= 1'b0;
    end else begin
      Mem_Write <= 1'b0;
      case (state)
        IDLE: begin
          if (Load_Enable) begin
            state          <= LOW;
            addr           <= '0;
            Word_Count     <= '0;
            Load_Done      <= 1'b0;
            Processor_Hold <= 1'b1;
          end
        end
        LOW: begin
          if (!Load_Enable) begin
            state          <= DONE;
            Load_Done      <= 1'b1;
            Processor_Hold <= 1'b0;
          end else if (press) begin
            if (Switches[16]) begin
              // End-of-program marker: nothing is written.
              state          <= DONE;
              Load_Done      <= 1'b1;
              Processor_Hold <= 1'b0;
            end else begin
              low_half <= Switches[15:0];
              state    <= HIGH;
            end
          end
        end
        HIGH: begin
          if (!Load_Enable) begin
            // Abort drops the half-entered word.
            state          <= DONE;
            Load_Done      <= 1'b1;
            Processor_Hold <= 1'b0;
          end else if (press) begin
            Mem_Write      <= 1'b1;
            Mem_Address    <= addr;
            Mem_Write_Data <= {Switches[15:0], low_half};
            state          <= WRITE;
          end
        end
        WRITE: begin
          Word_Count <= Word_Count + 1'b1;
          if (addr == ADDR_LAST || !Load_Enable) begin
            // Memory full (address never wraps) or abort after the write.
            if (addr != ADDR_LAST) begin
              addr <= addr + 1'b1;
            end
            state          <= DONE;
            Load_Done      <= 1'b1;
            Processor_Hold <= 1'b0;
          end else begin
            addr  <= addr + 1'b1;
            state <= LOW;
          end
        end
        DONE: begin
          if (!Load_Enable) begin
            state <= IDLE;
          end
        end
        default: begin
          state          <= IDLE;
          Processor_Hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed test of the program loader with a small memory
// (4 words) and a short debounce (4 cycles). Expected writes go into a queue;
// a monitor pops one entry per observed write strobe.
module tb_program_loader;

  localparam int AW = 2;
  localparam int DB = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOW   = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic          clock;
  logic          reset;
  logic [17:0]   Switches;
  logic          Load_Key;
  logic          Load_Enable;
  logic [AW-1:0] Mem_Address;
  logic [31:0]   Mem_Write_Data;
  logic          Mem_Write;
  logic          Processor_Hold;
  logic [AW:0]   Word_Count;
  logic          Load_Done;
  logic [2:0]    state_dbg;

  logic [AW+31:0] exp_q[$];
  int n_vec;
  int n_err;

  program_loader #(.ADDR_WIDTH(AW), .DEBOUNCE_CYCLES(DB)) dut (
    .clock          (clock),
    .reset          (reset),
    .Switches       (Switches),
    .Load_Key       (Load_Key),
    .Load_Enable    (Load_Enable),
    .Mem_Address    (Mem_Address),
    .Mem_Write_Data (Mem_Write_Data),
    .Mem_Write      (Mem_Write),
    .Processor_Hold (Processor_Hold),
    .Word_Count     (Word_Count),
    .Load_Done      (Load_Done),
    .state_dbg      (state_dbg)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the next expected write.
  always @(negedge clock) begin
    if (reset === 1'b0 && Mem_Write !== 1'b0) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 Mem_Address, Mem_Write_Data);
      end else begin
        logic [AW+31:0] e;
        e = exp_q.pop_front();
        if ({Mem_Address, Mem_Write_Data} !== e || Mem_Write !== 1'b1) begin
          n_err++;
          $display("FAIL write: got addr %0h data %0h strobe %b expected addr %0h data %0h",
                   Mem_Address, Mem_Write_Data, Mem_Write, e[AW+31:32], e[31:0]);
        end
      end
    end
  end

  // Driver: one debounced key press with the given half-word and end flag.
  task automatic press_half(input logic [15:0] half, input logic end_flag);
    Switches = {1'b0, end_flag, half};
    Load_Key = 1'b1;
    repeat (10) @(negedge clock);
    Load_Key = 1'b0;
    repeat (10) @(negedge clock);
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [15:0] lo, input logic [15:0] hi);
    exp_q.push_back({a, hi, lo});
    press_half(lo, 1'b0);
    press_half(hi, 1'b0);
  endtask

  task automatic set_enable(input logic en);
    Load_Enable = en;
    repeat (3) @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"},  64'(Mem_Address),    64'h0);
    check({tag, "_data"},  64'(Mem_Write_Data), 64'h0);
    check({tag, "_wr"},    64'(Mem_Write),      64'h0);
    check({tag, "_hold"},  64'(Processor_Hold), 64'h0);
    check({tag, "_count"}, 64'(Word_Count),     64'h0);
    check({tag, "_done"},  64'(Load_Done),      64'h0);
    check({tag, "_state"}, 64'(state_dbg),      64'(S_IDLE));
  endtask

  initial begin
    int lat;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    Switches = '0;
    Load_Key = 1'b0;
    Load_Enable = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Enter loader mode; hold asserted from the first LOW cycle.
    Load_Enable = 1'b1;
    @(negedge clock);
    check("enter_state", 64'(state_dbg), 64'(S_LOW));
    check("enter_hold", 64'(Processor_Hold), 64'h1);

    // Reset in the middle of a word: outputs clear without waiting for a clock.
    press_half(16'h1234, 1'b0);
    check("pre_reset_state", 64'(state_dbg), 64'(S_HIGH));
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("post_reset_state", 64'(state_dbg), 64'(S_LOW));

    // First word.
    load_word(2'd0, 16'h1234, 16'hABCD);
    check("w1_count", 64'(Word_Count), 64'h1);
    check("w1_state", 64'(state_dbg), 64'(S_LOW));

    // Fill the memory; the last address ends loading.
    load_word(2'd1, 16'h1111, 16'h2222);
    load_word(2'd2, 16'h3333, 16'h4444);
    load_word(2'd3, 16'h5555, 16'h6666);
    check("full_done", 64'(Load_Done), 64'h1);
    check("full_hold", 64'(Processor_Hold), 64'h0);
    check("full_count", 64'(Word_Count), 64'h4);
    check("full_state", 64'(state_dbg), 64'(S_DONE));
    press_half(16'h7777, 1'b0);
    press_half(16'h8888, 1'b0);
    check("extra_count", 64'(Word_Count), 64'h4);

    // Leaving loader mode keeps Load_Done until the next entry.
    set_enable(1'b0);
    check("idle_state", 64'(state_dbg), 64'(S_IDLE));
    check("idle_done", 64'(Load_Done), 64'h1);
    set_enable(1'b1);
    check("reenter_done", 64'(Load_Done), 64'h0);
    check("reenter_count", 64'(Word_Count), 64'h0);

    // Two words, then the end-of-program flag.
    load_word(2'd0, 16'hF00D, 16'h0BAD);
    load_word(2'd1, 16'hBEEF, 16'hDEAD);
    press_half(16'h7777, 1'b1);
    check("end_state", 64'(state_dbg), 64'(S_DONE));
    check("end_count", 64'(Word_Count), 64'h2);
    check("end_done", 64'(Load_Done), 64'h1);
    check("end_hold", 64'(Processor_Hold), 64'h0);

    // Abort after the low half: no write, count unchanged.
    set_enable(1'b0);
    set_enable(1'b1);
    press_half(16'h4321, 1'b0);
    check("abort_pre_state", 64'(state_dbg), 64'(S_HIGH));
    Load_Enable = 1'b0;
    @(negedge clock);
    check("abort_state", 64'(state_dbg), 64'(S_DONE));
    check("abort_count", 64'(Word_Count), 64'h0);
    check("abort_done", 64'(Load_Done), 64'h1);
    repeat (3) @(negedge clock);

    // Bouncing key: only the steady level after the bounce counts.
    set_enable(1'b1);
    check("bounce_start_state", 64'(state_dbg), 64'(S_LOW));
    Switches = {2'b00, 16'h5A5A};
    for (int c = 0; c < 20; c++) begin
      Load_Key = ((c / 2) % 2 == 0);
      @(negedge clock);
    end
    check("bounce_no_press", 64'(state_dbg), 64'(S_LOW));
    Load_Key = 1'b1;
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (state_dbg == S_HIGH) begin
        lat = i;
        break;
      end
    end
    // 2 synchronizer cycles + 4 debounce cycles + 1 FSM cycle.
    check("bounce_latency", 64'(lat), 64'd7);
    repeat (10) @(negedge clock);
    check("bounce_single", 64'(state_dbg), 64'(S_HIGH));
    Load_Key = 1'b0;
    repeat (10) @(negedge clock);
    exp_q.push_back({2'd0, 16'h0F0F, 16'h5A5A});
    press_half(16'h0F0F, 1'b0);
    check("bounce_count", 64'(Word_Count), 64'h1);

    repeat (5) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
